// File: rtl/instruction_pkg.sv
// rtl/instruction_pkg.sv - load funct3 codes, load sequencer states and legality helper
package instruction_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [3:0] MINST_NONE = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } load_state_t;

    // A load is rejected for an unknown funct3 or an address not aligned to its size
    function automatic logic load_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            LB, LBU:  bad = 1'b0;
            LH, LHU:  bad = addr_lo[0];
            LW:       bad = (addr_lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - select and sign/zero-extend a load from a memory word
module load_align
    import instruction_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend according to the load kind
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - data-memory load sequencer: request, response wait, align, writeback
module load_unit
    import instruction_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  minst_i,
    input  logic [31:0] addr_i,
    input  logic [4:0]  rd_i,
    input  logic        rdm_v_i,
    output logic        hazard_o,
    output logic        dreq_v_o,
    output logic [31:0] dreq_addr_o,
    input  logic        dreq_rdy_i,
    input  logic        drsp_v_i,
    input  logic [31:0] drsp_data_i,
    output logic        wb_v_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    // The counter is compared before incrementing, so the last WAIT cycle sees RESP_TIMEOUT-1
    localparam logic [9:0] TIMEOUT_LAST = 10'(RESP_TIMEOUT - 1);

    load_state_t state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;
    logic        rdm_v_q;
    logic [9:0]  cnt_q;
    logic [31:0] data_q;
    logic [31:0] dreq_addr_q;
    logic        hazard_q;
    logic        dreq_v_q;
    logic        wb_v_q;
    logic        err_q;
    logic [31:0] aligned;

    load_align u_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (drsp_data_i),
        .data    (aligned)
    );

    // Sequencer with registered outputs; reset drops any load in flight without error or writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            rdm_v_q     <= 1'b0;
            cnt_q       <= 10'd0;
            data_q      <= 32'h0;
            dreq_addr_q <= 32'h0;
            hazard_q    <= 1'b0;
            dreq_v_q    <= 1'b0;
            wb_v_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            wb_v_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!minst_i[3]) begin
                        funct3_q  <= minst_i[2:0];
                        addr_lo_q <= addr_i[1:0];
                        rd_q      <= rd_i;
                        rdm_v_q   <= rdm_v_i;
                        if (load_illegal(minst_i[2:0], addr_i[1:0])) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            dreq_addr_q <= {addr_i[31:2], 2'b00};
                            dreq_v_q    <= 1'b1;
                            hazard_q    <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dreq_rdy_i) begin
                        state_q  <= WAIT;
                        cnt_q    <= 10'd0;
                        dreq_v_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (drsp_v_i) begin
                        data_q   <= aligned;
                        state_q  <= WB;
                        hazard_q <= 1'b0;
                        wb_v_q   <= rdm_v_q;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                        hazard_q <= 1'b0;
                    end else if (cnt_q != 10'h3FF) begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hazard_o    = hazard_q;
    assign dreq_v_o    = dreq_v_q;
    assign dreq_addr_o = dreq_addr_q;
    assign wb_v_o      = wb_v_q;
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed table-driven bench for load_unit
module tb_load_unit;
    import instruction_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  minst = MINST_NONE;
    logic [31:0] addr = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        rdm_v = 1'b0;
    logic        hazard_o;
    logic        dreq_v_o;
    logic [31:0] dreq_addr_o;
    logic        dreq_rdy = 1'b0;
    logic        drsp_v = 1'b0;
    logic [31:0] drsp_data = 32'h0;
    logic        wb_v_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        rdm_v;
        logic [31:0] rsp;
        logic        exp_err;
        logic        exp_wb_v;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    load_unit #(.RESP_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .minst_i     (minst),
        .addr_i      (addr),
        .rd_i        (rd),
        .rdm_v_i     (rdm_v),
        .hazard_o    (hazard_o),
        .dreq_v_o    (dreq_v_o),
        .dreq_addr_o (dreq_addr_o),
        .dreq_rdy_i  (dreq_rdy),
        .drsp_v_i    (drsp_v),
        .drsp_data_i (drsp_data),
        .wb_v_o      (wb_v_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                                input logic rv, input logic [31:0] rsp, input logic e,
                                input logic wv, input logic [31:0] d);
        vec_t v;
        v.funct3 = f3; v.addr = a; v.rd = r; v.rdm_v = rv; v.rsp = rsp;
        v.exp_err = e; v.exp_wb_v = wv; v.exp_data = d;
        return v;
    endfunction

    // One load with immediate handshake and response; caller leaves the DUT idle, #1 after an edge
    task automatic run_vec(input string tag, input vec_t v);
        minst = {1'b0, v.funct3};
        addr  = v.addr;
        rd    = v.rd;
        rdm_v = v.rdm_v;
        tick();
        minst = MINST_NONE;
        if (v.exp_err) begin
            check({tag, " err pulse"}, 32'(err_o), 32'd1);
            check({tag, " no req"}, 32'(dreq_v_o), 32'd0);
            check({tag, " no hazard"}, 32'(hazard_o), 32'd0);
            tick();
            check({tag, " err end"}, 32'(err_o), 32'd0);
            check({tag, " no req later"}, 32'(dreq_v_o), 32'd0);
            check({tag, " no wb"}, 32'(wb_v_o), 32'd0);
        end else begin
            check({tag, " req v"}, 32'(dreq_v_o), 32'd1);
            check({tag, " req hazard"}, 32'(hazard_o), 32'd1);
            check({tag, " req addr"}, dreq_addr_o, {v.addr[31:2], 2'b00});
            check({tag, " req err"}, 32'(err_o), 32'd0);
            dreq_rdy = 1'b1;
            tick();
            dreq_rdy = 1'b0;
            check({tag, " wait req off"}, 32'(dreq_v_o), 32'd0);
            check({tag, " wait hazard"}, 32'(hazard_o), 32'd1);
            drsp_v = 1'b1;
            drsp_data = v.rsp;
            tick();
            drsp_v = 1'b0;
            check({tag, " wb v"}, 32'(wb_v_o), 32'(v.exp_wb_v));
            check({tag, " wb hazard"}, 32'(hazard_o), 32'd0);
            check({tag, " wb data"}, wb_data_o, v.exp_data);
            if (v.exp_wb_v) check({tag, " wb rd"}, 32'(wb_rd_o), 32'(v.rd));
            tick();
            check({tag, " wb off"}, 32'(wb_v_o), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " hazard"}, 32'(hazard_o), 32'd0);
        check({tag, " dreq_v"}, 32'(dreq_v_o), 32'd0);
        check({tag, " dreq_addr"}, dreq_addr_o, 32'h0);
        check({tag, " wb_v"}, 32'(wb_v_o), 32'd0);
        check({tag, " wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, " wb_data"}, wb_data_o, 32'h0);
        check({tag, " err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        vecs.push_back(mk(LB,  32'h0000_1003, 5'd5,  1'b1, 32'h80FF_1234, 1'b0, 1'b1, 32'hFFFF_FF80));
        vecs.push_back(mk(LHU, 32'h0000_2002, 5'd6,  1'b1, 32'h8765_4321, 1'b0, 1'b1, 32'h0000_8765));
        vecs.push_back(mk(LH,  32'h0000_2002, 5'd7,  1'b1, 32'h8765_4321, 1'b0, 1'b1, 32'hFFFF_8765));
        vecs.push_back(mk(LBU, 32'h0000_1003, 5'd8,  1'b1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0080));
        vecs.push_back(mk(LB,  32'h0000_1001, 5'd9,  1'b1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0012));
        vecs.push_back(mk(LBU, 32'h0000_1002, 5'd10, 1'b1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_00FF));
        vecs.push_back(mk(LH,  32'h0000_2000, 5'd11, 1'b1, 32'h8765_4321, 1'b0, 1'b1, 32'h0000_4321));
        vecs.push_back(mk(LW,  32'h0000_3000, 5'd12, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D));
        vecs.push_back(mk(LW,  32'h0000_3001, 5'd13, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(LH,  32'h0000_2003, 5'd14, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(LHU, 32'h0000_2001, 5'd15, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(3'd3, 32'h0000_0000, 5'd16, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(3'd6, 32'h0000_0000, 5'd17, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(3'd7, 32'h0000_0000, 5'd18, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0));

        // Reset state
        #12;
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("post reset idle");

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Request back-pressure: address and valid held for 6 cycles
        minst = {1'b0, LW}; addr = 32'h0000_0044; rd = 5'd7; rdm_v = 1'b1;
        tick();
        minst = MINST_NONE; addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall v c%0d", i), 32'(dreq_v_o), 32'd1);
            check($sformatf("stall addr c%0d", i), dreq_addr_o, 32'h0000_0044);
            check($sformatf("stall hazard c%0d", i), 32'(hazard_o), 32'd1);
            if (i == 5) dreq_rdy = 1'b1;
            tick();
        end
        dreq_rdy = 1'b0;
        check("stall wait hazard", 32'(hazard_o), 32'd1);
        drsp_v = 1'b1; drsp_data = 32'h1234_5678;
        tick();
        drsp_v = 1'b0;
        check("stall wb v", 32'(wb_v_o), 32'd1);
        check("stall wb data", wb_data_o, 32'h1234_5678);
        check("stall wb rd", 32'(wb_rd_o), 32'd7);
        tick();

        // Response timeout after 4 WAIT cycles, then a late response is ignored
        minst = {1'b0, LW}; addr = 32'h0000_0050; rd = 5'd3; rdm_v = 1'b1;
        tick();
        minst = MINST_NONE;
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to wait hazard c%0d", i), 32'(hazard_o), 32'd1);
            check($sformatf("to wait err c%0d", i), 32'(err_o), 32'd0);
            tick();
        end
        check("to err pulse", 32'(err_o), 32'd1);
        check("to hazard off", 32'(hazard_o), 32'd0);
        check("to no wb", 32'(wb_v_o), 32'd0);
        drsp_v = 1'b1; drsp_data = 32'h5555_AAAA;
        tick();
        drsp_v = 1'b0;
        check("to err end", 32'(err_o), 32'd0);
        check("late rsp no wb", 32'(wb_v_o), 32'd0);
        check("late rsp no hazard", 32'(hazard_o), 32'd0);
        tick();
        check("late rsp no wb 2", 32'(wb_v_o), 32'd0);
        run_vec("after timeout", mk(LW, 32'h0000_0010, 5'd4, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF));

        // Asynchronous reset while waiting for the response
        minst = {1'b0, LW}; addr = 32'h0000_0060; rd = 5'd9; rdm_v = 1'b1;
        tick();
        minst = MINST_NONE;
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        check("pre reset hazard", 32'(hazard_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async reset");
        tick();
        reset = 1'b1;
        drsp_v = 1'b1; drsp_data = 32'h7777_7777;
        tick();
        drsp_v = 1'b0;
        check("rsp after reset wb", 32'(wb_v_o), 32'd0);
        check("rsp after reset hazard", 32'(hazard_o), 32'd0);
        tick();
        check("rsp after reset wb 2", 32'(wb_v_o), 32'd0);
        check("rsp after reset data", wb_data_o, 32'h0);

        // rd = x0: access performed, no writeback strobe
        minst = {1'b0, LW}; addr = 32'h0000_0040; rd = 5'd0; rdm_v = 1'b0;
        tick();
        minst = MINST_NONE;
        check("x0 req issued", 32'(dreq_v_o), 32'd1);
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        drsp_v = 1'b1; drsp_data = 32'h1111_1111;
        tick();
        drsp_v = 1'b0;
        check("x0 no wb", 32'(wb_v_o), 32'd0);
        check("x0 wb hazard", 32'(hazard_o), 32'd0);
        tick();
        check("x0 no wb later", 32'(wb_v_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Sequencer for the data-memory read path behind the execution stage. Accepts a load decoded by execution (`minst`, effective address, `rd`), issues one word-aligned read over a valid/ready request channel, waits for the response, then aligns and sign- or zero-extends the data and presents one writeback. It drives the execution stage's `hazard_x` stall while a load is outstanding and flags misaligned, illegal or timed-out loads.

## Interface
- `RESP_TIMEOUT`, 255: WAIT-state cycles before a load is abandoned; range 1..1023.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `minst_i`  in  4  memory op from execution; `4'b11xx` = none, `{1'b0,funct3}` = load.
- `addr_i`  in  32  effective address, execution `rd_data` in the load cycle.
- `rd_i`  in  5  destination register.
- `rdm_v_i`  in  1  destination valid (rd != x0).
- `hazard_o`  out  1  stall to execution (`hazard_x`).
- `dreq_v_o`  out  1  read request valid.
- `dreq_addr_o`  out  32  request address, `{addr[31:2],2'b00}`.
- `dreq_rdy_i`  in  1  request accepted.
- `drsp_v_i`  in  1  response valid, single-cycle pulse.
- `drsp_data_i`  in  32  response word.
- `wb_v_o`  out  1  writeback strobe.
- `wb_rd_o`  out  5  writeback register.
- `wb_data_o`  out  32  extended load data.
- `err_o`  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE: accept when `minst_i[3]==0`. Capture `addr_i`, `funct3=minst_i[2:0]`, `rd_i` and `rdm_v_i`.
  - Legal, aligned load: go to REQ.
  - funct3 in {3,6,7}, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: pulse `err_o` next cycle and stay in IDLE. No request, no writeback.
- REQ: `dreq_v_o=1`. Address is held stable until `dreq_rdy_i`. On `dreq_rdy_i`, go to WAIT and clear the timeout counter.
- WAIT: on `drsp_v_i`, register the aligned data and go to WB.
  - Otherwise increment the counter. When it reaches `RESP_TIMEOUT`, pulse `err_o` and go to IDLE with no writeback.
- WB: `wb_v_o = rdm_v`, `wb_rd_o = rd`, `wb_data_o` = registered data. Return to IDLE.
  - A load with rd=x0 performs the access but never strobes `wb_v_o`.
- Extraction by captured addr[1:0]:
  - LB / LBU: byte `addr[1:0]`, sign- / zero-extended.
  - LH / LHU: half `addr[1]`, sign- / zero-extended.
  - LW: full word.
- `drsp_v_i` is ignored outside WAIT. This covers stale responses after timeout or reset.
- `hazard_o = 1` in REQ and WAIT. It is 0 in IDLE and WB, so execution advances in the writeback cycle.

## Timing
- Reset values: state IDLE, counter 0; `hazard_o`, `dreq_v_o`, `wb_v_o`, `err_o` = 0; `dreq_addr_o`, `wb_rd_o`, `wb_data_o` = 0.
- Reset asserted mid-operation aborts immediately: no writeback, no error, request dropped.
- Cycle 0: accept. Cycle 1: REQ (`dreq_v_o`, `hazard_o`).
- Best case: `dreq_rdy_i` in cycle 1 and `drsp_v_i` in cycle 2 give WB in cycle 3. Minimum latency is 3 cycles from accept to `wb_v_o`.
- A new load may be accepted in the cycle after WB, or the cycle after an error pulse.
- A response can never coincide with the request handshake: WAIT is entered only after `dreq_rdy_i`.
- Counter: 10 bits, saturating.

## Structure
- `instruction_pkg` additions:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - `load_state_t` enum {IDLE, REQ, WAIT, WB}.
  - Localparam `MINST_NONE=4'b1100`.
- Sub-module `load_align`: combinational function of (funct3, addr[1:0], word) → 32-bit extended data. It is reused by a later store/AMO path.

## Test plan
- LB at 0x1003, response 0x80FF_1234 → `wb_data_o`=0xFFFF_FF80, `wb_rd_o`=rd, WB exactly 3 cycles after accept with rdy/rsp immediate.
- LHU at 0x2002, response 0x8765_4321 → 0x0000_8765. LH with the same inputs → 0xFFFF_8765. `dreq_addr_o`=0x2000.
- LW at 0x3001 → `err_o` pulse, `dreq_v_o` never high, `hazard_o` never high, no `wb_v_o`.
- `dreq_rdy_i` held low 5 cycles → `dreq_v_o` and `dreq_addr_o` stable for 6 cycles, `hazard_o` high throughout.
- RESP_TIMEOUT=4, no response → `err_o` after 4 WAIT cycles, back to IDLE. A late `drsp_v_i` is ignored, and the next LW at 0x10 with response 0xDEADBEEF writes 0xDEADBEEF.
- Reset low while in WAIT → all outputs 0 asynchronously. The response after release is ignored. LW with rd=x0 → request issued, `wb_v_o` stays 0.
